// File: rtl/mbus_rx_buffer.sv
`default_nettype none

// ============================================================================
// Module      : mbus_rx_buffer
// Description : Receive-side word FIFO for the MBus layer wrapper. Words arrive
//               over a 4-phase REQ/ACK handshake. They become visible to the
//               consumer only once their whole message has been received.
//               An aborted message is rolled back. A message that cannot fit is
//               dropped and flagged in OVERFLOW.
//               Optional feature macro: MBUS_RX_BCAST_FILTER_EN
//               (defined -> broadcast words are acknowledged and dropped).
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mbus_rx_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = `ADDR_WIDTH,
    parameter int DW    = `DATA_WIDTH
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    input  logic [AW-1:0]           RX_ADDR,
    input  logic [DW-1:0]           RX_DATA,
    input  logic                    RX_REQ,
    input  logic                    RX_PEND,
    input  logic                    RX_BROADCAST,
    input  logic                    RX_FAIL,
    output logic                    RX_ACK,
    output logic [AW-1:0]           OUT_ADDR,
    output logic [DW-1:0]           OUT_DATA,
    output logic                    OUT_LAST,
    output logic                    OUT_BCAST,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [$clog2(DEPTH):0]  WORD_COUNT,
    output logic                    OVERFLOW,
    input  logic                    CLR_OVERFLOW
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int EW = AW + DW + 2;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HOLD     = 2'd1,
        S_DISCARD  = 2'd2,
        S_WAIT_LOW = 2'd3
    } state_t;

    // Synchronizer and edge-detect registers
    logic req_meta_q, req_s_q;
    logic fail_meta_q, fail_s_q, fail_prev_q;

    // Write-side state
    state_t         state_q, state_d;
    logic           ack_q, ack_d;
    logic           disc_last_q, disc_last_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  commit_ptr_q, commit_ptr_d;

    // Read-side state
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic           valid_q, valid_d;
    logic           ovf_q, ovf_d;

    // Storage
    logic [EW-1:0]  mem_q [DEPTH];

    // Combinational helpers
    logic           w_fail_rise;
    logic           w_full;
    logic [PW-1:0]  w_committed;
    logic           w_wr_en;
    logic           w_ovf_set;
    logic           w_pop;

    assign w_fail_rise = fail_s_q & ~fail_prev_q;
    assign w_full      = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    assign w_committed = commit_ptr_q - rd_ptr_q;
    assign w_pop       = valid_q & OUT_READY;

    // Two-flop synchronizers for the asynchronous REQ and FAIL levels
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            req_meta_q  <= 1'b0;
            req_s_q     <= 1'b0;
            fail_meta_q <= 1'b0;
            fail_s_q    <= 1'b0;
            fail_prev_q <= 1'b0;
        end else begin
            req_meta_q  <= RX_REQ;
            req_s_q     <= req_meta_q;
            fail_meta_q <= RX_FAIL;
            fail_s_q    <= fail_meta_q;
            fail_prev_q <= fail_s_q;
        end
    end

    // Write FSM: handshake, store, commit, rollback and overflow decisions
    always_comb begin
        state_d      = state_q;
        ack_d        = ack_q;
        disc_last_d  = disc_last_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        w_wr_en      = 1'b0;
        w_ovf_set    = 1'b0;

        // Abort: drop everything written since the last commit point
        if (w_fail_rise) begin
            wr_ptr_d = commit_ptr_q;
        end

        case (state_q)
            S_IDLE, S_HOLD: begin
                if (!req_s_q) begin
                    state_d = S_IDLE;
                end else if (fail_s_q) begin
                    // Word belongs to an aborted message: acknowledge, do not store
                    ack_d   = 1'b1;
                    state_d = S_WAIT_LOW;
`ifdef MBUS_RX_BCAST_FILTER_EN
                end else if (RX_BROADCAST) begin
                    ack_d       = 1'b1;
                    disc_last_d = ~RX_PEND;
                    state_d     = S_DISCARD;
`endif
                end else if (!w_full) begin
                    w_wr_en  = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    if (!RX_PEND) begin
                        commit_ptr_d = wr_ptr_q + PW'(1);
                    end
                    ack_d   = 1'b1;
                    state_d = S_WAIT_LOW;
                end else if (w_committed != '0) begin
                    // Consumer will free space; stall the wrapper until then
                    state_d = S_HOLD;
                end else begin
                    // Message alone fills the FIFO and can never fit: drop it
                    wr_ptr_d    = commit_ptr_q;
                    w_ovf_set   = 1'b1;
                    ack_d       = 1'b1;
                    disc_last_d = ~RX_PEND;
                    state_d     = S_DISCARD;
                end
            end

            S_DISCARD: begin
                if (fail_s_q) begin
                    disc_last_d = 1'b1;
                end
                if (ack_q) begin
                    if (!req_s_q) begin
                        ack_d = 1'b0;
                        if (disc_last_q || fail_s_q) begin
                            state_d = S_IDLE;
                        end
                    end
                end else if (req_s_q) begin
                    ack_d       = 1'b1;
                    disc_last_d = ~RX_PEND | fail_s_q;
                end else if (fail_s_q) begin
                    state_d = S_IDLE;
                end
            end

            S_WAIT_LOW: begin
                if (!req_s_q) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    // Read side: pop advances rd_ptr; valid follows the registered commit point
    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(w_pop);
        valid_d  = (commit_ptr_q != rd_ptr_d);
        ovf_d    = ovf_q;
        if (CLR_OVERFLOW) begin
            ovf_d = 1'b0;
        end
        if (w_ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    // State and pointer registers
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q      <= S_IDLE;
            ack_q        <= 1'b0;
            disc_last_q  <= 1'b0;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            disc_last_q  <= disc_last_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
        end
    end

    // Entry storage; contents need no reset because pointers gate visibility
    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q[IW-1:0]] <= {RX_ADDR, RX_DATA, ~RX_PEND, RX_BROADCAST};
        end
    end

    assign {OUT_ADDR, OUT_DATA, OUT_LAST, OUT_BCAST} = mem_q[rd_ptr_q[IW-1:0]];
    assign OUT_VALID  = valid_q;
    assign RX_ACK     = ack_q;
    assign WORD_COUNT = w_committed;
    assign OVERFLOW   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mbus_rx_buffer.sv
`default_nettype none

// ============================================================================
// Module      : tb_mbus_rx_buffer
// Description : Directed, table-driven bench for mbus_rx_buffer (DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_mbus_rx_buffer;

    logic        clk;
    logic        RESETn;
    logic [7:0]  RX_ADDR;
    logic [31:0] RX_DATA;
    logic        RX_REQ, RX_PEND, RX_BROADCAST, RX_FAIL;
    logic        RX_ACK;
    logic [7:0]  OUT_ADDR;
    logic [31:0] OUT_DATA;
    logic        OUT_LAST, OUT_BCAST, OUT_VALID, OUT_READY;
    logic [3:0]  WORD_COUNT;
    logic        OVERFLOW, CLR_OVERFLOW;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic seen_valid;

    mbus_rx_buffer #(.DEPTH(8), .AW(8), .DW(32)) dut (
        .CLK          (clk),
        .RESETn       (RESETn),
        .RX_ADDR      (RX_ADDR),
        .RX_DATA      (RX_DATA),
        .RX_REQ       (RX_REQ),
        .RX_PEND      (RX_PEND),
        .RX_BROADCAST (RX_BROADCAST),
        .RX_FAIL      (RX_FAIL),
        .RX_ACK       (RX_ACK),
        .OUT_ADDR     (OUT_ADDR),
        .OUT_DATA     (OUT_DATA),
        .OUT_LAST     (OUT_LAST),
        .OUT_BCAST    (OUT_BCAST),
        .OUT_VALID    (OUT_VALID),
        .OUT_READY    (OUT_READY),
        .WORD_COUNT   (WORD_COUNT),
        .OVERFLOW     (OVERFLOW),
        .CLR_OVERFLOW (CLR_OVERFLOW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        pend;
        logic [3:0]  exp_wc;
        logic        exp_valid;
    } wvec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        last;
    } pvec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic req_up(input logic [7:0] a, input logic [31:0] d, input logic p, input logic b);
        RX_ADDR      = a;
        RX_DATA      = d;
        RX_PEND      = p;
        RX_BROADCAST = b;
        RX_REQ       = 1'b1;
    endtask

    // Wait (at negedges) until RX_ACK reaches lvl or the budget runs out
    task automatic wait_ack(input logic lvl, input int budget, output int cyc);
        cyc = 0;
        while (RX_ACK !== lvl && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (OUT_VALID === 1'b1) seen_valid = 1'b1;
        end
    endtask

    task automatic send_word(input logic [7:0] a, input logic [31:0] d, input logic p, input logic b);
        int c;
        req_up(a, d, p, b);
        wait_ack(1'b1, 20, c);
        chk("ack_rise", RX_ACK, 1);
        RX_REQ = 1'b0;
        wait_ack(1'b0, 20, c);
        chk("ack_fall", RX_ACK, 0);
    endtask

    task automatic pop_chk(input logic [7:0] a, input logic [31:0] d, input logic last, input logic bc);
        chk("pop_valid", OUT_VALID, 1);
        chk("pop_addr",  OUT_ADDR,  a);
        chk("pop_data",  OUT_DATA,  d);
        chk("pop_last",  OUT_LAST,  last);
        chk("pop_bcast", OUT_BCAST, bc);
        OUT_READY = 1'b1;
        @(posedge clk);
        #1;
        OUT_READY = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wvec_t msg3 [3];
        pvec_t pop3 [3];
        int    lat;

        msg3[0] = '{addr: 8'h10, data: 32'h11, pend: 1'b1, exp_wc: 4'd0, exp_valid: 1'b0};
        msg3[1] = '{addr: 8'h11, data: 32'h22, pend: 1'b1, exp_wc: 4'd0, exp_valid: 1'b0};
        msg3[2] = '{addr: 8'h12, data: 32'h33, pend: 1'b0, exp_wc: 4'd3, exp_valid: 1'b1};
        pop3[0] = '{addr: 8'h10, data: 32'h11, last: 1'b0};
        pop3[1] = '{addr: 8'h11, data: 32'h22, last: 1'b0};
        pop3[2] = '{addr: 8'h12, data: 32'h33, last: 1'b1};

        RESETn = 1'b0; RX_ADDR = '0; RX_DATA = '0; RX_REQ = 1'b0; RX_PEND = 1'b0;
        RX_BROADCAST = 1'b0; RX_FAIL = 1'b0; OUT_READY = 1'b0; CLR_OVERFLOW = 1'b0;
        seen_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack",   RX_ACK,     0);
        chk("rst_valid", OUT_VALID,  0);
        chk("rst_wc",    WORD_COUNT, 0);
        chk("rst_ovf",   OVERFLOW,   0);
        RESETn = 1'b1;
        repeat (2) @(negedge clk);

        // 3-word message: nothing visible until the last word commits
        for (int i = 0; i < 3; i++) begin
            req_up(msg3[i].addr, msg3[i].data, msg3[i].pend, 1'b0);
            wait_ack(1'b1, 20, lat);
            chk("m3_ack_rise", RX_ACK, 1);
            if (i == 0) chk("m3_ack_latency", 64'(lat), 3);
            if (i == 2) begin
                chk("m3_valid_at_commit", OUT_VALID, 0);
                chk("m3_wc_at_commit", WORD_COUNT, 3);
            end
            RX_REQ = 1'b0;
            wait_ack(1'b0, 20, lat);
            chk("m3_ack_fall", RX_ACK, 0);
            chk("m3_wc", WORD_COUNT, msg3[i].exp_wc);
            chk("m3_valid", OUT_VALID, msg3[i].exp_valid);
        end
        for (int i = 0; i < 3; i++) pop_chk(pop3[i].addr, pop3[i].data, pop3[i].last, 1'b0);
        chk("m3_empty_wc", WORD_COUNT, 0);
        chk("m3_empty_valid", OUT_VALID, 0);

        // Abort after 2 words with one committed entry present
        send_word(8'h20, 32'hA1, 1'b0, 1'b0);
        send_word(8'h21, 32'hB1, 1'b1, 1'b0);
        send_word(8'h22, 32'hB2, 1'b1, 1'b0);
        RX_FAIL = 1'b1;
        repeat (4) @(negedge clk);
        RX_FAIL = 1'b0;
        repeat (4) @(negedge clk);
        chk("fail_wc", WORD_COUNT, 1);
        chk("fail_ovf", OVERFLOW, 0);
        send_word(8'h23, 32'hC1, 1'b0, 1'b0);
        chk("fail_next_wc", WORD_COUNT, 2);
        pop_chk(8'h20, 32'hA1, 1'b1, 1'b0);
        pop_chk(8'h23, 32'hC1, 1'b1, 1'b0);

        // Full FIFO of committed entries: stall, then resume after one pop
        for (int i = 0; i < 8; i++) send_word(8'(i), 32'h100 + i, 1'b0, 1'b0);
        chk("full_wc", WORD_COUNT, 8);
        req_up(8'h3F, 32'h1FF, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        chk("full_ack_held", RX_ACK, 0);
        pop_chk(8'h00, 32'h100, 1'b1, 1'b0);
        wait_ack(1'b1, 4, lat);
        chk("full_retry_ack", RX_ACK, 1);
        RX_REQ = 1'b0;
        wait_ack(1'b0, 20, lat);
        chk("full_ack_fall", RX_ACK, 0);
        chk("full_wc_after", WORD_COUNT, 8);
        for (int i = 1; i < 8; i++) pop_chk(8'(i), 32'h100 + i, 1'b1, 1'b0);
        pop_chk(8'h3F, 32'h1FF, 1'b1, 1'b0);

        // 9-word message into an empty FIFO; CLR held so set-wins is visible
        seen_valid   = 1'b0;
        CLR_OVERFLOW = 1'b1;
        for (int i = 0; i < 9; i++) begin
            req_up(8'h40 + 8'(i), 32'h200 + i, (i != 8), 1'b0);
            wait_ack(1'b1, 20, lat);
            chk("ovf_ack_rise", RX_ACK, 1);
            if (i == 8) begin
                chk("ovf_set_wins", OVERFLOW, 1);
                CLR_OVERFLOW = 1'b0;
            end
            RX_REQ = 1'b0;
            wait_ack(1'b0, 20, lat);
            chk("ovf_ack_fall", RX_ACK, 0);
        end
        repeat (3) @(negedge clk);
        chk("ovf_flag", OVERFLOW, 1);
        chk("ovf_wc", WORD_COUNT, 0);
        chk("ovf_valid", OUT_VALID, 0);
        chk("ovf_seen_valid", seen_valid, 0);
        CLR_OVERFLOW = 1'b1;
        @(negedge clk);
        CLR_OVERFLOW = 1'b0;
        chk("ovf_clear", OVERFLOW, 0);
        send_word(8'h50, 32'h300, 1'b0, 1'b0);
        chk("ovf_recover_wc", WORD_COUNT, 1);
        pop_chk(8'h50, 32'h300, 1'b1, 1'b0);

        // Broadcast single-word message
        send_word(8'h60, 32'h400, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
`ifdef MBUS_RX_BCAST_FILTER_EN
        chk("bcast_wc", WORD_COUNT, 0);
        chk("bcast_valid", OUT_VALID, 0);
        chk("bcast_ovf", OVERFLOW, 0);
`else
        chk("bcast_wc", WORD_COUNT, 1);
        pop_chk(8'h60, 32'h400, 1'b1, 1'b1);
`endif

        // Reset while waiting for REQ to fall, mid-message
        send_word(8'h70, 32'h500, 1'b1, 1'b0);
        req_up(8'h71, 32'h501, 1'b1, 1'b0);
        wait_ack(1'b1, 20, lat);
        chk("rst_mid_ack_before", RX_ACK, 1);
        RESETn = 1'b0;
        #1;
        chk("rst_mid_ack",   RX_ACK,     0);
        chk("rst_mid_valid", OUT_VALID,  0);
        chk("rst_mid_wc",    WORD_COUNT, 0);
        chk("rst_mid_ovf",   OVERFLOW,   0);
        @(negedge clk);
        RX_REQ = 1'b0;
        @(negedge clk);
        RESETn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_after_ack", RX_ACK, 0);
        chk("rst_after_wc", WORD_COUNT, 0);
        send_word(8'h7A, 32'h510, 1'b0, 1'b0);
        chk("rst_new_msg_wc", WORD_COUNT, 1);
        pop_chk(8'h7A, 32'h510, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
